// File: rtl/byte_memory.sv
`default_nettype none
//==============================================================================
// Module   : byte_memory
// Brief    : Word-organised RAM with a read-only fetch port and a byte-lane
//            data port; misaligned data accesses split over two words.
// Revision : 1.0
//==============================================================================
module byte_memory #(
   parameter int MEMORY_DEPTH     = 1024,
   parameter bit ALLOW_MISALIGNED = 1'b1,
   parameter int XLEN             = 32,
   parameter int LS_SEL_WIDTH     = 2
) (
   input  logic                    i_Clock,
   input  logic                    i_Reset_N,
   input  logic                    i_Instruction_Enable,
   input  logic [XLEN-1:0]         i_Instruction_Addr,
   output logic [XLEN-1:0]         o_Instruction,
   input  logic                    i_Data_Request,
   input  logic                    i_Write_Enable,
   input  logic [LS_SEL_WIDTH:0]   i_Load_Store_Type,
   input  logic [XLEN-1:0]         i_Data_Addr,
   input  logic [XLEN-1:0]         i_Write_Data,
   output logic                    o_Data_Ready,
   output logic                    o_Data_Valid,
   output logic [XLEN-1:0]         o_Read_Data,
   output logic                    o_Misaligned_Fault
);

   localparam int c_IDX_W = $clog2(MEMORY_DEPTH);
   localparam int c_LANES = XLEN / 8;

   // Store encodings share these values: the low bits give the size.
   localparam logic [LS_SEL_WIDTH:0] c_LS_TYPE_LOAD_BYTE          = 3'b000;
   localparam logic [LS_SEL_WIDTH:0] c_LS_TYPE_LOAD_HALF          = 3'b001;
   localparam logic [LS_SEL_WIDTH:0] c_LS_TYPE_LOAD_WORD          = 3'b010;
   localparam logic [LS_SEL_WIDTH:0] c_LS_TYPE_LOAD_BYTE_UNSIGNED = 3'b100;
   localparam logic [LS_SEL_WIDTH:0] c_LS_TYPE_LOAD_HALF_UNSIGNED = 3'b101;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [XLEN-1:0]         r_mem [MEMORY_DEPTH];

   logic                    r_ready;
   logic [XLEN-1:0]         r_lo_word;
   logic [XLEN-1:0]         r_hi_data;
   logic [c_LANES-1:0]      r_hi_be;
   logic [c_IDX_W-1:0]      r_hi_idx;
   logic [1:0]              r_off;
   logic [LS_SEL_WIDTH:0]   r_type;
   logic                    r_we;

   logic [c_IDX_W-1:0]      w_idx;
   logic [c_IDX_W-1:0]      w_fetch_idx;
   logic [1:0]              w_off;
   logic [c_LANES-1:0]      w_size_mask;
   logic                    w_supported;
   logic [2*c_LANES-1:0]    w_be_wide;
   logic [2*XLEN-1:0]       w_wdata_wide;
   logic                    w_misaligned;
   logic                    w_fault;
   logic                    w_accept;
   logic                    w_go_split;
   logic                    w_in_split;

   logic                    w_mem_we;
   logic [c_IDX_W-1:0]      w_mem_idx;
   logic [c_LANES-1:0]      w_mem_be;
   logic [XLEN-1:0]         w_mem_wdata;
   logic [XLEN-1:0]         w_rd_word;

   logic [2*XLEN-1:0]       w_merge;
   logic [1:0]              w_load_off;
   logic [LS_SEL_WIDTH:0]   w_load_type;
   logic [XLEN-1:0]         w_load_raw;
   logic [XLEN-1:0]         w_load_result;
   logic                    w_unused_bits;

   function automatic logic [XLEN-1:0] f_extend(
      input logic [XLEN-1:0]       raw,
      input logic [LS_SEL_WIDTH:0] ls_type
   );
      f_extend = '0;
      case (ls_type)
         c_LS_TYPE_LOAD_BYTE:          f_extend = {{(XLEN-8){raw[7]}}, raw[7:0]};
         c_LS_TYPE_LOAD_HALF:          f_extend = {{(XLEN-16){raw[15]}}, raw[15:0]};
         c_LS_TYPE_LOAD_WORD:          f_extend = raw;
         c_LS_TYPE_LOAD_BYTE_UNSIGNED: f_extend = {{(XLEN-8){1'b0}}, raw[7:0]};
         c_LS_TYPE_LOAD_HALF_UNSIGNED: f_extend = {{(XLEN-16){1'b0}}, raw[15:0]};
         default:                      f_extend = '0;
      endcase
   endfunction

   assign w_idx       = i_Data_Addr[c_IDX_W+1:2];
   assign w_off       = i_Data_Addr[1:0];
   assign w_fetch_idx = i_Instruction_Addr[c_IDX_W+1:2];
   assign w_in_split  = (r_state == SPLIT);

   assign w_unused_bits = ^{i_Data_Addr[XLEN-1:c_IDX_W+2],
                            i_Instruction_Addr[XLEN-1:c_IDX_W+2],
                            i_Instruction_Addr[1:0]};

   always_comb begin
      w_size_mask = '0;
      w_supported = 1'b1;
      case (i_Load_Store_Type)
         c_LS_TYPE_LOAD_BYTE, c_LS_TYPE_LOAD_BYTE_UNSIGNED: w_size_mask = 4'b0001;
         c_LS_TYPE_LOAD_HALF, c_LS_TYPE_LOAD_HALF_UNSIGNED: w_size_mask = 4'b0011;
         c_LS_TYPE_LOAD_WORD:                               w_size_mask = 4'b1111;
         default:                                           w_supported = 1'b0;
      endcase
   end

   // Shifting over a two-word window: any enable landing in the upper half
   // means the access crosses into the next word.
   assign w_be_wide    = {{c_LANES{1'b0}}, w_size_mask} << w_off;
   assign w_wdata_wide = {{XLEN{1'b0}}, i_Write_Data} << {w_off, 3'b000};
   assign w_misaligned = |w_be_wide[2*c_LANES-1:c_LANES];
   assign w_fault      = w_misaligned && !ALLOW_MISALIGNED;

   assign o_Data_Ready = r_ready && (r_state == IDLE);
   assign w_accept     = i_Data_Request && o_Data_Ready;
   assign w_go_split   = w_accept && w_supported && w_misaligned && ALLOW_MISALIGNED;

   assign w_mem_we    = w_in_split ? r_we
                                   : (w_accept && i_Write_Enable && w_supported && !w_fault);
   assign w_mem_idx   = w_in_split ? r_hi_idx  : w_idx;
   assign w_mem_be    = w_in_split ? r_hi_be   : w_be_wide[c_LANES-1:0];
   assign w_mem_wdata = w_in_split ? r_hi_data : w_wdata_wide[XLEN-1:0];
   assign w_rd_word   = r_mem[w_mem_idx];

   // Both halves are merged before extraction so sign extension sees the true top byte.
   assign w_merge       = w_in_split ? {w_rd_word, r_lo_word} : {{XLEN{1'b0}}, w_rd_word};
   assign w_load_off    = w_in_split ? r_off  : w_off;
   assign w_load_type   = w_in_split ? r_type : i_Load_Store_Type;
   assign w_load_raw    = w_merge[{w_load_off, 3'b000} +: XLEN];
   assign w_load_result = f_extend(w_load_raw, w_load_type);

   always_ff @(posedge i_Clock or negedge i_Reset_N) begin
      if (!i_Reset_N) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_go_split) w_state_next = SPLIT;
         SPLIT:   w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_Clock or negedge i_Reset_N) begin
      if (!i_Reset_N) begin
         r_ready            <= 1'b0;
         o_Data_Valid       <= 1'b0;
         o_Misaligned_Fault <= 1'b0;
         o_Read_Data        <= '0;
         r_lo_word          <= '0;
         r_hi_data          <= '0;
         r_hi_be            <= '0;
         r_hi_idx           <= '0;
         r_off              <= '0;
         r_type             <= '0;
         r_we               <= 1'b0;
      end else begin
         r_ready            <= 1'b1;
         o_Data_Valid       <= 1'b0;
         o_Misaligned_Fault <= 1'b0;
         if (w_in_split) begin
            o_Data_Valid <= 1'b1;
            o_Read_Data  <= r_we ? '0 : w_load_result;
         end else if (w_go_split) begin
            r_lo_word <= w_rd_word;
            r_hi_data <= w_wdata_wide[2*XLEN-1:XLEN];
            r_hi_be   <= w_be_wide[2*c_LANES-1:c_LANES];
            r_hi_idx  <= w_idx + c_IDX_W'(1);
            r_off     <= w_off;
            r_type    <= i_Load_Store_Type;
            r_we      <= i_Write_Enable;
         end else if (w_accept) begin
            o_Data_Valid       <= 1'b1;
            o_Misaligned_Fault <= w_supported && w_fault;
            o_Read_Data        <= (!i_Write_Enable && w_supported && !w_fault)
                                  ? w_load_result : '0;
         end
      end
   end

   always_ff @(posedge i_Clock or negedge i_Reset_N) begin
      if (!i_Reset_N) begin
         o_Instruction <= '0;
      end else if (i_Instruction_Enable) begin
         o_Instruction <= r_mem[w_fetch_idx];
      end
   end

   // Array has no reset so its contents survive a reset pulse.
   always_ff @(posedge i_Clock) begin
      if (w_mem_we) begin
         for (int k = 0; k < c_LANES; k++) begin
            if (w_mem_be[k]) begin
               r_mem[w_mem_idx][8*k +: 8] <= w_mem_wdata[8*k +: 8];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_byte_memory.sv
`default_nettype none
//==============================================================================
// Module   : tb_byte_memory
// Brief    : Scoreboard bench for byte_memory, one instance allowing and one
//            faulting misaligned accesses.
// Revision : 1.0
//==============================================================================
module tb_byte_memory;

   localparam int DEPTH = 1024;
   localparam int BYTES = 4 * DEPTH;
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] BAD = 3'b011;

   typedef struct {
      logic [31:0] data;
      logic        fault;
      bit          chk_data;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        instr_en;
   logic [31:0] instr_addr;
   logic [31:0] instr_a, instr_n;
   logic        req_a, req_n, we;
   logic [2:0]  ls_type;
   logic [31:0] addr, wdata;
   logic        ready_a, valid_a, fault_a;
   logic        ready_n, valid_n, fault_n;
   logic [31:0] rdata_a, rdata_n;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   exp_t        q_a[$];
   exp_t        q_n[$];
   logic [7:0]  mem_a [BYTES];
   logic [7:0]  mem_n [BYTES];

   byte_memory #(.MEMORY_DEPTH(DEPTH), .ALLOW_MISALIGNED(1'b1), .XLEN(32)) u_dut_a (
      .i_Clock(clk), .i_Reset_N(rst_n),
      .i_Instruction_Enable(instr_en), .i_Instruction_Addr(instr_addr), .o_Instruction(instr_a),
      .i_Data_Request(req_a), .i_Write_Enable(we), .i_Load_Store_Type(ls_type),
      .i_Data_Addr(addr), .i_Write_Data(wdata),
      .o_Data_Ready(ready_a), .o_Data_Valid(valid_a), .o_Read_Data(rdata_a),
      .o_Misaligned_Fault(fault_a)
   );

   byte_memory #(.MEMORY_DEPTH(DEPTH), .ALLOW_MISALIGNED(1'b0), .XLEN(32)) u_dut_n (
      .i_Clock(clk), .i_Reset_N(rst_n),
      .i_Instruction_Enable(instr_en), .i_Instruction_Addr(instr_addr), .o_Instruction(instr_n),
      .i_Data_Request(req_n), .i_Write_Enable(we), .i_Load_Store_Type(ls_type),
      .i_Data_Addr(addr), .i_Write_Data(wdata),
      .o_Data_Ready(ready_n), .o_Data_Valid(valid_n), .o_Read_Data(rdata_n),
      .o_Misaligned_Fault(fault_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int size_of(input logic [2:0] t);
      case (t[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit supported(input logic [2:0] t);
      return (t[1:0] != 2'b11) && (t != 3'b110);
   endfunction

   function automatic logic [31:0] model_load(input bit sel, input logic [2:0] t, input logic [31:0] a);
      logic [31:0] raw;
      logic [31:0] ba;
      raw = '0;
      for (int i = 0; i < size_of(t); i++) begin
         ba = (a + 32'(i)) & 32'(BYTES - 1);
         raw[8*i +: 8] = sel ? mem_n[ba] : mem_a[ba];
      end
      case (t)
         LB:      return {{24{raw[7]}}, raw[7:0]};
         LH:      return {{16{raw[15]}}, raw[15:0]};
         LW:      return raw;
         LBU:     return {24'h0, raw[7:0]};
         LHU:     return {16'h0, raw[15:0]};
         default: return '0;
      endcase
   endfunction

   task automatic model_store(input bit sel, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] ba;
      for (int i = 0; i < size_of(t); i++) begin
         ba = (a + 32'(i)) & 32'(BYTES - 1);
         if (sel) mem_n[ba] = d[8*i +: 8];
         else     mem_a[ba] = d[8*i +: 8];
      end
   endtask

   // Drives one request right after a rising edge and returns just after its accept edge.
   task automatic issue(input bit sel, input logic w, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d, input bit expect_resp = 1'b1);
      exp_t e;
      int   budget;
      bit   mis;
      budget = 0;
      while (!(sel ? ready_n : ready_a) && budget < 20) begin
         @(posedge clk); #1;
         budget++;
      end
      if (budget >= 20) begin
         check_value("ready_timeout", 32'd0, 32'd1);
         return;
      end
      we = w; ls_type = t; addr = a; wdata = d;
      if (sel) req_n = 1'b1;
      else     req_a = 1'b1;
      if (expect_resp) begin
         mis        = (int'(a[1:0]) + size_of(t)) > 4;
         e.data     = '0;
         e.fault    = 1'b0;
         e.chk_data = 1'b1;
         e.cyc      = cyc + 1;
         if (supported(t)) begin
            if (mis && sel) begin
               e.fault = 1'b1;
            end else begin
               if (mis) e.cyc = cyc + 2;
               if (w) begin
                  model_store(sel, t, a, d);
                  e.chk_data = 1'b0;
               end else begin
                  e.data = model_load(sel, t, a);
               end
            end
         end
         if (sel) q_n.push_back(e);
         else     q_a.push_back(e);
      end
      @(posedge clk); #1;
      req_a = 1'b0;
      req_n = 1'b0;
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (rst_n === 1'b1) begin
         if (valid_a) begin
            if (q_a.size() == 0) begin
               check_value("a_spurious_valid", 32'd1, 32'd0);
            end else begin
               e = q_a.pop_front();
               if (e.chk_data) check_value("a_rdata", rdata_a, e.data);
               check_value("a_fault", {31'd0, fault_a}, {31'd0, e.fault});
               check_value("a_latency", cyc, e.cyc);
            end
         end else if (fault_a) begin
            check_value("a_fault_without_valid", {31'd0, fault_a}, 32'd0);
         end
      end
   end

   always @(negedge clk) begin : mon_n
      exp_t e;
      if (rst_n === 1'b1) begin
         if (valid_n) begin
            if (q_n.size() == 0) begin
               check_value("n_spurious_valid", 32'd1, 32'd0);
            end else begin
               e = q_n.pop_front();
               if (e.chk_data) check_value("n_rdata", rdata_n, e.data);
               check_value("n_fault", {31'd0, fault_n}, {31'd0, e.fault});
               check_value("n_latency", cyc, e.cyc);
            end
         end else if (fault_n) begin
            check_value("n_fault_without_valid", {31'd0, fault_n}, 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] old_word;
      rst_n = 1'b0; req_a = 1'b0; req_n = 1'b0; we = 1'b0; ls_type = '0;
      addr = '0; wdata = '0; instr_en = 1'b0; instr_addr = '0;

      repeat (3) @(posedge clk);
      #1;
      check_value("rst_ready_a", {31'd0, ready_a}, 32'd0);
      check_value("rst_ready_n", {31'd0, ready_n}, 32'd0);
      check_value("rst_valid_a", {31'd0, valid_a}, 32'd0);
      check_value("rst_fault_a", {31'd0, fault_a}, 32'd0);
      check_value("rst_rdata_a", rdata_a, 32'd0);
      check_value("rst_instr_a", instr_a, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_value("ready_before_edge", {31'd0, ready_a}, 32'd0);
      @(posedge clk); #1;
      check_value("ready_first_edge", {31'd0, ready_a}, 32'd1);

      // Aligned traffic, back to back
      issue(0, 1, LW,  32'h0, 32'h11223344);
      issue(0, 0, LBU, 32'h1, 32'h0);
      issue(0, 0, LH,  32'h0, 32'h0);
      issue(0, 0, LHU, 32'h2, 32'h0);
      issue(0, 0, LB,  32'h3, 32'h0);
      issue(0, 0, LW,  32'h0, 32'h0);

      issue(0, 1, LW,  32'h4, 32'h0);
      issue(0, 1, LB,  32'h6, 32'h00000080);
      issue(0, 0, LB,  32'h6, 32'h0);
      issue(0, 0, LW,  32'h4, 32'h0);
      issue(0, 0, LH,  32'h6, 32'h0);
      issue(0, 0, LBU, 32'h6, 32'h0);

      // Misaligned split accesses
      issue(0, 1, LW,  32'h0, 32'hAABBCCDD);
      issue(0, 1, LW,  32'h4, 32'h11223344);
      issue(0, 0, LW,  32'h3, 32'h0);
      check_value("split_ready_low", {31'd0, ready_a}, 32'd0);
      @(posedge clk); #1;
      check_value("split_ready_back", {31'd0, ready_a}, 32'd1);
      issue(0, 0, LH,  32'h3, 32'h0);
      issue(0, 1, LH,  32'h7, 32'h0000BEEF);
      issue(0, 0, LH,  32'h7, 32'h0);
      issue(0, 1, LW,  32'h1, 32'hDEADBEEF);
      issue(0, 0, LW,  32'h0, 32'h0);
      issue(0, 0, LW,  32'h4, 32'h0);

      // Wrap from the top word into word 0
      issue(0, 1, LW,  32'hFFC, 32'h0);
      issue(0, 1, LW,  32'h0,   32'h0);
      issue(0, 1, LH,  32'(BYTES - 1), 32'h0000BEEF);
      issue(0, 0, LBU, 32'(BYTES - 1), 32'h0);
      issue(0, 0, LW,  32'hFFC,  32'h0);
      issue(0, 0, LW,  32'h0,    32'h0);
      issue(0, 0, LH,  32'(BYTES - 1), 32'h0);
      issue(0, 0, LBU, 32'h1000, 32'h0);

      // Unsupported encodings
      issue(0, 1, BAD,    32'h0, 32'hFFFFFFFF);
      issue(0, 1, 3'b110, 32'h0, 32'hFFFFFFFF);
      issue(0, 0, BAD,    32'h0, 32'h0);
      issue(0, 0, LW,     32'h0, 32'h0);

      // Faulting instance
      issue(1, 1, LW, 32'h0, 32'h55667788);
      issue(1, 1, LW, 32'h2, 32'h12345678);
      issue(1, 0, LW, 32'h0, 32'h0);
      issue(1, 0, LH, 32'h3, 32'h0);
      issue(1, 0, LH, 32'h2, 32'h0);
      issue(1, 0, LW, 32'h1, 32'h0);

      // Fetch port, including same-edge write of the fetched word
      repeat (3) @(posedge clk);
      #1;
      instr_en = 1'b1;
      instr_addr = 32'h7;
      @(posedge clk); #1;
      check_value("fetch_word1", instr_a, model_load(0, LW, 32'h4));
      issue(0, 1, LW, 32'h8, 32'h01020304);
      instr_addr = 32'h8;
      old_word = model_load(0, LW, 32'h8);
      issue(0, 1, LW, 32'h8, 32'hCAFEF00D);
      check_value("fetch_read_first", instr_a, old_word);
      @(posedge clk); #1;
      check_value("fetch_new", instr_a, 32'hCAFEF00D);
      instr_en = 1'b0;
      instr_addr = 32'h0;
      @(posedge clk); #1;
      check_value("fetch_hold", instr_a, 32'hCAFEF00D);

      // Reset in the middle of a split store
      issue(0, 1, LW, 32'h0, 32'h0);
      issue(0, 1, LW, 32'h4, 32'h12345678);
      instr_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      issue(0, 1, LW, 32'h1, 32'hDDCCBBAA, 1'b0);
      rst_n = 1'b0;
      #1;
      check_value("abort_valid", {31'd0, valid_a}, 32'd0);
      check_value("abort_ready", {31'd0, ready_a}, 32'd0);
      check_value("abort_instr", instr_a, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check_value("abort_valid_hold", {31'd0, valid_a}, 32'd0);
      mem_a[1] = 8'hAA;
      mem_a[2] = 8'hBB;
      mem_a[3] = 8'hCC;
      @(negedge clk);
      rst_n = 1'b1;
      instr_en = 1'b0;
      @(posedge clk); #1;
      issue(0, 0, LW, 32'h0, 32'h0);
      issue(0, 0, LW, 32'h4, 32'h0);

      repeat (5) @(posedge clk);
      #1;
      check_value("a_pending", 32'(q_a.size()), 32'd0);
      check_value("n_pending", 32'(q_n.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
